// File: rtl/sraa_encoder_sequencer_if.sv
// Handshake and SRAA control bundle between the encoder sequencer and its neighbours.
// The systematic-output pair exists only when SRAA_SYSTEMATIC_OUT_EN is defined.
interface sraa_encoder_sequencer_if #(
  parameter int unsigned ADDR_W = 2
) ();
  logic              start;
  logic              info_valid;
  logic              info_bit_in;
  logic              info_ready;
  logic [ADDR_W-1:0] gen_addr;
  logic              load_shift_reg;
  logic              shift_en;
  logic              load_reg;
  logic              sraa_clear;
  logic              info_bit;
  logic              busy;
  logic              parity_valid;
  logic              parity_ready;
`ifdef SRAA_SYSTEMATIC_OUT_EN
  logic              sys_valid;
  logic              sys_bit;

  modport master (
    input  start, info_valid, info_bit_in, parity_ready,
    output info_ready, gen_addr, load_shift_reg, shift_en, load_reg, sraa_clear, info_bit,
           busy, parity_valid, sys_valid, sys_bit
  );

  modport slave (
    output start, info_valid, info_bit_in, parity_ready,
    input  info_ready, gen_addr, load_shift_reg, shift_en, load_reg, sraa_clear, info_bit,
           busy, parity_valid, sys_valid, sys_bit
  );
`else
  modport master (
    input  start, info_valid, info_bit_in, parity_ready,
    output info_ready, gen_addr, load_shift_reg, shift_en, load_reg, sraa_clear, info_bit,
           busy, parity_valid
  );

  modport slave (
    output start, info_valid, info_bit_in, parity_ready,
    input  info_ready, gen_addr, load_shift_reg, shift_en, load_reg, sraa_clear, info_bit,
           busy, parity_valid
  );
`endif
endinterface

// File: rtl/sraa_encoder_sequencer.sv
// Sequencer feeding the QC-LDPC SRAA unit: frames NUM_INFO_CIRC blocks of CIRC_SIZE info bits.
// Optional feature macro: SRAA_SYSTEMATIC_OUT_EN (adds sys_valid/sys_bit to the interface).
module sraa_encoder_sequencer #(
  parameter int unsigned CIRC_SIZE     = 88,
  parameter int unsigned NUM_INFO_CIRC = 4,
  parameter int unsigned ADDR_W        = 2
) (
  input logic                      clk,
  input logic                      clear,
  sraa_encoder_sequencer_if.master bus
);

  localparam int unsigned BitW = (CIRC_SIZE > 1) ? $clog2(CIRC_SIZE) : 1;

  if (ADDR_W < $clog2(NUM_INFO_CIRC)) begin : gen_addr_w_check
    $error("ADDR_W too narrow for NUM_INFO_CIRC");
  end

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StLoad,
    StAcc,
    StDrain,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] blk_cnt_q, blk_cnt_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              pend_q, pend_d;
  logic              info_bit_q, info_bit_d;

  logic accept;
  logic last_bit;
  logic last_blk;

  assign accept   = (state_q == StAcc) && bus.info_valid;
  assign last_bit = (bit_cnt_q == BitW'(CIRC_SIZE - 1));
  assign last_blk = (blk_cnt_q == ADDR_W'(NUM_INFO_CIRC - 1));

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= StIdle;
      blk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      pend_q     <= 1'b0;
      info_bit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_cnt_q  <= blk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      pend_q     <= pend_d;
      info_bit_q <= info_bit_d;
    end
  end

  // bit_cnt counts accepted bits so the block exit is decided on the accepting edge itself.
  always_comb begin
    state_d    = state_q;
    blk_cnt_d  = blk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    pend_d     = accept;
    info_bit_d = accept ? bus.info_bit_in : info_bit_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = StClr;
      end
      StClr: begin
        blk_cnt_d = '0;
        state_d   = StLoad;
      end
      StLoad: begin
        bit_cnt_d = '0;
        state_d   = StAcc;
      end
      StAcc: begin
        if (accept) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (last_bit) begin
            if (last_blk) begin
              state_d = StDrain;
            end else begin
              blk_cnt_d = blk_cnt_q + 1'b1;
              state_d   = StLoad;
            end
          end
        end
      end
      StDrain: begin
        state_d = StDone;
      end
      StDone: begin
        if (bus.parity_ready) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // The final bit of a block retires during the next block's LOAD cycle; the accumulator
  // still sees the old circulant row because the reload only lands at the end of that cycle.
  assign bus.info_ready     = (state_q == StAcc);
  assign bus.gen_addr       = blk_cnt_q;
  assign bus.load_shift_reg = (state_q == StLoad);
  assign bus.shift_en       = pend_q;
  assign bus.load_reg       = pend_q;
  assign bus.sraa_clear     = (state_q == StClr);
  assign bus.info_bit       = info_bit_q;
  assign bus.busy           = (state_q != StIdle);
  assign bus.parity_valid   = (state_q == StDone);

`ifdef SRAA_SYSTEMATIC_OUT_EN
  assign bus.sys_valid = pend_q;
  assign bus.sys_bit   = info_bit_q;
`else
  // No systematic outputs in this build.
`endif

endmodule
